register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/riscv_pkg.sv | 12 +
 rtl/register_file.sv | 82 ++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared core-wide parameters and types used by the register file, operand
// multiplexor and ALU stages.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;

endpackage : riscv_pkg

// File: rtl/register_file.sv
// Architectural integer register file: two combinational read ports with
// write-first forwarding, one write port, x0 hard-wired to zero.
module register_file #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    input  logic [XLEN-1:0]          rd_data,
    input  logic                     rd_we,
    output logic [15:0]              wr_count
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] rf_q [NREGS];
    logic [15:0]     wr_count_reg;
    logic            commit;

    // Addresses past the last register only exist when NREGS is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    function automatic logic [XLEN-1:0] forward(
        input logic [AW-1:0]   rs,
        input logic            wr_en,
        input logic [AW-1:0]   wr_addr,
        input logic [XLEN-1:0] wr_data,
        input logic [XLEN-1:0] stored
    );
        if (wr_en && (rs == wr_addr)) begin
            return wr_data;
        end
        return stored;
    endfunction

    // A write only lands (and only forwards) when it targets a real, non-x0 register outside reset.
    assign commit = rd_we && (rd_addr != '0) && in_range(rd_addr) && !rst;

    assign rf_q[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (commit && (rd_addr == AW'(gi))) begin
                    q_reg <= rd_data;
                end
            end

            assign rf_q[gi] = q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_reg <= '0;
        end else if (commit && (wr_count_reg != 16'hFFFF)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    always_comb begin
        rs1_data = forward(rs1_addr, commit, rd_addr, rd_data,
                           in_range(rs1_addr) ? rf_q[rs1_addr] : '0);
        rs2_data = forward(rs2_addr, commit, rd_addr, rd_data,
                           in_range(rs2_addr) ? rf_q[rs2_addr] : '0);
    end

    assign wr_count = wr_count_reg;

endmodule : register_file
